// File: rtl/neighbor_scan_ctrl.sv
// Region-query sequencer: fetches the query point, then streams every candidate through the
// shared distance unit and emits neighbour indices. Optional macro NSC_SELF_EXCLUDE_EN drops the query point itself.
module neighbor_scan_ctrl #(
    parameter int IDX_W = 8,
    parameter int CNT_W = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W-1:0] query_idx,
    input  logic [CNT_W-1:0] num_points,
    input  logic [15:0]      r2,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] neighbor_count,
    output logic             mem_rd_en,
    output logic [IDX_W-1:0] mem_addr,
    input  logic [7:0]       mem_x,
    input  logic [7:0]       mem_y,
    input  logic [7:0]       mem_z,
    output logic [7:0]       du_x1,
    output logic [7:0]       du_y1,
    output logic [7:0]       du_z1,
    output logic [7:0]       du_x2,
    output logic [7:0]       du_y2,
    output logic [7:0]       du_z2,
    output logic [15:0]      du_r2,
    input  logic             du_is_neighbor,
    output logic             nb_valid,
    input  logic             nb_ready,
    output logic [IDX_W-1:0] nb_idx
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_Q, S_CAP_Q, S_READ, S_EVAL, S_EMIT, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] qidx_q, qidx_d;
    logic [CNT_W-1:0] np_q, np_d;
    logic [15:0]      r2_q, r2_d;
    logic [7:0]       qx_q, qx_d, qy_q, qy_d, qz_q, qz_d;
    logic [7:0]       cx_q, cx_d, cy_q, cy_d, cz_q, cz_d;
    logic [CNT_W-1:0] i_q, i_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] nbidx_q, nbidx_d;
    logic             last_cand;
    logic             hit;

    // Termination compares against num_points-1 so i never needs to wrap.
    assign last_cand = (i_q == np_q - CNT_W'(1));

`ifdef NSC_SELF_EXCLUDE_EN
    assign hit = du_is_neighbor && (i_q != CNT_W'(qidx_q));
`else
    assign hit = du_is_neighbor;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_LOAD_Q;
            S_LOAD_Q: state_d = S_CAP_Q;
            S_CAP_Q:  state_d = (np_q == '0) ? S_DONE : S_READ;
            S_READ:   state_d = S_EVAL;
            S_EVAL: begin
                if (hit)            state_d = S_EMIT;
                else if (last_cand) state_d = S_DONE;
                else                state_d = S_READ;
            end
            S_EMIT:   if (nb_ready) state_d = last_cand ? S_DONE : S_READ;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        qidx_d  = qidx_q;
        np_d    = np_q;
        r2_d    = r2_q;
        qx_d    = qx_q;
        qy_d    = qy_q;
        qz_d    = qz_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        cz_d    = cz_q;
        i_d     = i_q;
        cnt_d   = cnt_q;
        nbidx_d = nbidx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    qidx_d = query_idx;
                    np_d   = num_points;
                    r2_d   = r2;
                    cnt_d  = '0;
                    i_d    = '0;
                end
            end
            S_CAP_Q: begin
                qx_d = mem_x;
                qy_d = mem_y;
                qz_d = mem_z;
            end
            S_EVAL: begin
                // Keep the candidate so the distance-unit inputs stay put during EMIT.
                cx_d = mem_x;
                cy_d = mem_y;
                cz_d = mem_z;
                if (hit) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    nbidx_d = i_q[IDX_W-1:0];
                end else if (!last_cand) begin
                    i_d = i_q + CNT_W'(1);
                end
            end
            S_EMIT: begin
                if (nb_ready && !last_cand) i_d = i_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qidx_q  <= '0;
            np_q    <= '0;
            r2_q    <= '0;
            qx_q    <= '0;
            qy_q    <= '0;
            qz_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            cz_q    <= '0;
            i_q     <= '0;
            cnt_q   <= '0;
            nbidx_q <= '0;
        end else begin
            qidx_q  <= qidx_d;
            np_q    <= np_d;
            r2_q    <= r2_d;
            qx_q    <= qx_d;
            qy_q    <= qy_d;
            qz_q    <= qz_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            cz_q    <= cz_d;
            i_q     <= i_d;
            cnt_q   <= cnt_d;
            nbidx_q <= nbidx_d;
        end
    end

    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
        nb_valid       = (state_q == S_EMIT);
        mem_rd_en      = (state_q == S_LOAD_Q) || (state_q == S_READ);
        mem_addr       = (state_q == S_LOAD_Q) ? qidx_q : i_q[IDX_W-1:0];
        neighbor_count = cnt_q;
        nb_idx         = nbidx_q;
        du_x1          = qx_q;
        du_y1          = qy_q;
        du_z1          = qz_q;
        du_r2          = r2_q;
        // Memory output is live during EVAL; afterwards the held copy takes over.
        if (state_q == S_EVAL) begin
            du_x2 = mem_x;
            du_y2 = mem_y;
            du_z2 = mem_z;
        end else begin
            du_x2 = cx_q;
            du_y2 = cy_q;
            du_z2 = cz_q;
        end
    end

endmodule

// File: tb/tb_neighbor_scan_ctrl.sv
// Directed bench for neighbor_scan_ctrl with a point-memory and distance-unit model.
// Expectations follow NSC_SELF_EXCLUDE_EN when it is defined for the build.
module tb_neighbor_scan_ctrl;
    localparam int IDX_W = 8;
    localparam int CNT_W = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [IDX_W-1:0] query_idx = '0;
    logic [CNT_W-1:0] num_points = '0;
    logic [15:0]      r2 = '0;
    logic             busy, done, mem_rd_en, nb_valid;
    logic [CNT_W-1:0] neighbor_count;
    logic [IDX_W-1:0] mem_addr, nb_idx;
    logic [7:0]       mem_x = '0, mem_y = '0, mem_z = '0;
    logic [7:0]       du_x1, du_y1, du_z1, du_x2, du_y2, du_z2;
    logic [15:0]      du_r2;
    logic             du_is_neighbor;
    logic             nb_ready = 1'b0;

    neighbor_scan_ctrl #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .query_idx(query_idx),
        .num_points(num_points), .r2(r2), .busy(busy), .done(done),
        .neighbor_count(neighbor_count), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_x(mem_x), .mem_y(mem_y), .mem_z(mem_z),
        .du_x1(du_x1), .du_y1(du_y1), .du_z1(du_z1),
        .du_x2(du_x2), .du_y2(du_y2), .du_z2(du_z2), .du_r2(du_r2),
        .du_is_neighbor(du_is_neighbor), .nb_valid(nb_valid), .nb_ready(nb_ready),
        .nb_idx(nb_idx)
    );

    always #5 clk = ~clk;

    logic [7:0] mx [256];
    logic [7:0] my [256];
    logic [7:0] mz [256];

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_x <= mx[mem_addr];
            mem_y <= my[mem_addr];
            mem_z <= mz[mem_addr];
        end
    end

    int dx, dy, dz;
    always_comb begin
        dx = int'(du_x1) - int'(du_x2);
        dy = int'(du_y1) - int'(du_y2);
        dz = int'(du_z1) - int'(du_z2);
        du_is_neighbor = (dx * dx + dy * dy + dz * dz) < int'(du_r2);
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        int np; int q; int r2; int pat; int stall;
        int exp_cnt; int exp_mask; int exp_last; int exp_cyc;
    } vec_t;
    vec_t vecs [9];

    // pattern 0: every point (10,10,10); pattern 1: (0,0,0),(3,4,0),(10,0,0), rest far away
    task automatic load_pattern(input int pat);
        for (int k = 0; k < 256; k++) begin
            if (pat == 0) begin
                mx[k] = 8'd10; my[k] = 8'd10; mz[k] = 8'd10;
            end else begin
                mx[k] = 8'd200; my[k] = 8'd200; mz[k] = 8'd200;
            end
        end
        if (pat == 1) begin
            mx[0] = 8'd0;  my[0] = 8'd0; mz[0] = 8'd0;
            mx[1] = 8'd3;  my[1] = 8'd4; mz[1] = 8'd0;
            mx[2] = 8'd10; my[2] = 8'd0; mz[2] = 8'd0;
        end
    endtask

    task automatic run_scan(input vec_t v, input int vi);
        int cycles, emitted, mask, last, stall, idx_bad, rd_bad, held_cnt;
        logic seen_done, prev_wait;
        logic [IDX_W-1:0] prev_idx;
        load_pattern(v.pat);
        @(negedge clk);
        query_idx  = IDX_W'(v.q);
        num_points = CNT_W'(v.np);
        r2         = 16'(v.r2);
        start      = 1'b1;
        nb_ready   = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 0; emitted = 0; mask = 0; last = -1; stall = v.stall;
        idx_bad = 0; rd_bad = 0; seen_done = 1'b0; prev_wait = 1'b0; prev_idx = '0;
        while (!seen_done && cycles < 2000) begin
            start    = 1'b0;
            nb_ready = 1'b0;
            if (done) begin
                seen_done = 1'b1;
            end else begin
                if (nb_valid) begin
                    if (mem_rd_en) rd_bad++;
                    if (prev_wait && nb_idx != prev_idx) idx_bad++;
                    prev_idx = nb_idx;
                    if (stall > 0) begin
                        stall--;
                        prev_wait = 1'b1;
                        if (stall == 2) begin
                            // start and new inputs while busy must have no effect
                            start = 1'b1; query_idx = 8'd99; num_points = 9'd1; r2 = 16'd0;
                        end
                    end else begin
                        nb_ready = 1'b1;
                        prev_wait = 1'b0;
                        emitted++;
                        last = int'(nb_idx);
                        if (nb_idx < 16) mask = mask | (1 << nb_idx);
                    end
                end
                @(posedge clk); #1;
                cycles++;
            end
        end
        start = 1'b0;
        nb_ready = 1'b0;
        chk($sformatf("v%0d_done_seen", vi), int'(seen_done), 1);
        chk($sformatf("v%0d_done_cycle", vi), cycles, v.exp_cyc);
        chk($sformatf("v%0d_count", vi), int'(neighbor_count), v.exp_cnt);
        chk($sformatf("v%0d_emitted", vi), emitted, v.exp_cnt);
        chk($sformatf("v%0d_mask", vi), mask, v.exp_mask);
        chk($sformatf("v%0d_last_idx", vi), last, v.exp_last);
        if (v.stall > 0) begin
            chk($sformatf("v%0d_idx_stable", vi), idx_bad, 0);
            chk($sformatf("v%0d_rd_during_emit", vi), rd_bad, 0);
        end
        held_cnt = int'(neighbor_count);
        @(posedge clk); #1;
        chk($sformatf("v%0d_busy_after", vi), int'(busy), 0);
        chk($sformatf("v%0d_done_pulse", vi), int'(done), 0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_count_held", vi), int'(neighbor_count), held_cnt);
    endtask

    initial begin
        int waited, pulses;
        //            np   q   r2 pat stall cnt  mask    last cyc
`ifdef NSC_SELF_EXCLUDE_EN
        vecs[0] = '{4,   0,  1,  0, 0,    3,  'hE,    3,   13};
        vecs[1] = '{3,   0,  26, 1, 0,    1,  'h2,    1,   9};
        vecs[5] = '{3,   1,  26, 1, 5,    1,  'h1,    0,   14};
        vecs[7] = '{256, 255, 1, 0, 0,    255, 'hFFFF, 254, 769};
        vecs[8] = '{1,   0,  1,  0, 0,    0,  'h0,    -1,  4};
`else
        vecs[0] = '{4,   0,  1,  0, 0,    4,  'hF,    3,   14};
        vecs[1] = '{3,   0,  26, 1, 0,    2,  'h3,    1,   10};
        vecs[5] = '{3,   1,  26, 1, 5,    2,  'h3,    1,   15};
        vecs[7] = '{256, 255, 1, 0, 0,    256, 'hFFFF, 255, 770};
        vecs[8] = '{1,   0,  1,  0, 0,    1,  'h1,    0,   5};
`endif
        vecs[2] = '{0,   5,  100, 0, 0,   0,  'h0,    -1,  2};
        vecs[3] = '{4,   2,  0,  0, 0,    0,  'h0,    -1,  10};
        vecs[4] = '{5,   7,  1,  0, 0,    5,  'h1F,   4,   17};
        vecs[6] = '{256, 0,  0,  0, 0,    0,  'h0,    -1,  514};

        load_pattern(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_mem_rd_en", int'(mem_rd_en), 0);
        chk("rst_nb_valid", int'(nb_valid), 0);
        chk("rst_count", int'(neighbor_count), 0);
        chk("rst_addr_idx", int'({mem_addr, nb_idx}), 0);
        chk("rst_du", int'({du_x1, du_y1, du_z1, du_x2, du_y2, du_z2} != '0) + int'(du_r2), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while a neighbour is pending: everything drops at once, no done afterwards.
        @(negedge clk);
        query_idx = 8'd0; num_points = 9'd4; r2 = 16'd1; start = 1'b1; nb_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        waited = 0;
        while (!nb_valid && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("rstmid_reached_emit", int'(nb_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_nb_valid", int'(nb_valid), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_count", int'(neighbor_count), 0);
        chk("rstmid_du_x1", int'(du_x1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        chk("rstmid_no_done", pulses, 0);

        for (int vi = 0; vi < 9; vi++) begin
            run_scan(vecs[vi], vi);
            $display("vec %0d np=%0d q=%0d r2=%0d count=%0d", vi, vecs[vi].np, vecs[vi].q,
                     vecs[vi].r2, neighbor_count);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neighbor_scan_ctrl.md
Name: neighbor_scan_ctrl

Overview:
Sequences the shared combinational distance unit for one region query of the LiDAR clustering flow. On `start` it fetches the query point from point memory, then walks candidate indices 0..num_points-1. Each candidate is presented to the distance unit together with the query point. Indices of neighbours leave on a valid/ready stream, and a neighbour count is reported at completion. The block sits between point memory, the distance unit and the cluster-expansion logic.

Parameters:
- `IDX_W`, 8, width of a point index; memory depth is 2^IDX_W.
- `CNT_W`, IDX_W+1, width of `neighbor_count`; holds up to 2^IDX_W.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a scan; sampled only in IDLE.
- `query_idx`  in  IDX_W  index of the query point; captured on accepted start.
- `num_points`  in  CNT_W  number of valid points, 0..2^IDX_W; captured on accepted start.
- `r2`  in  16  squared radius; captured on accepted start.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the scan completes.
- `neighbor_count`  out  CNT_W  neighbours found; valid from `done`, held until the next accepted start.
- `mem_rd_en`  out  1  point-memory read strobe.
- `mem_addr`  out  IDX_W  point-memory read address.
- `mem_x`, `mem_y`, `mem_z`  in  8 each  point-memory read data; valid 1 cycle after `mem_rd_en`.
- `du_x1`, `du_y1`, `du_z1`  out  8 each  query coordinates to the distance unit.
- `du_x2`, `du_y2`, `du_z2`  out  8 each  candidate coordinates to the distance unit.
- `du_r2`  out  16  captured `r2`.
- `du_is_neighbor`  in  1  distance-unit result (combinational, same cycle).
- `nb_valid`  out  1  neighbour index available.
- `nb_ready`  in  1  consumer accepts the index.
- `nb_idx`  out  IDX_W  neighbour index.

Behaviour:
- Reset (async, `rst_n`=0):
  - State goes to IDLE.
  - `busy`, `done`, `mem_rd_en`, `nb_valid` = 0.
  - `neighbor_count`, `mem_addr`, `nb_idx` = 0.
  - Query, candidate and `r2` registers = 0.
  - `du_*` outputs = 0.
- Reset mid-scan aborts immediately: no `done`, and any pending `nb_valid` is dropped.
- FSM states: IDLE, LOAD_Q, CAP_Q, READ, EVAL, EMIT, DONE.
  - IDLE: `start`=1 captures `query_idx`, `num_points` and `r2`, clears `neighbor_count` and the candidate counter `i`, then goes to LOAD_Q. `start` is ignored in all other states.
  - LOAD_Q: `mem_rd_en`=1, `mem_addr`=query_idx, then go to CAP_Q.
  - CAP_Q: latch `mem_x/y/z` into the query registers. If `num_points`=0, go to DONE; else go to READ.
  - READ: `mem_rd_en`=1, `mem_addr`=i, then go to EVAL.
  - EVAL:
    - Candidate data drives `du_x2/y2/z2`; `du_is_neighbor` is sampled this cycle.
    - If it is a neighbour (subject to the optional feature): increment `neighbor_count`, load `nb_idx`=i, go to EMIT.
    - Otherwise, if i=num_points-1 go to DONE; else i++ and go to READ.
  - EMIT:
    - `nb_valid`=1 and `nb_idx` is held stable until `nb_ready`=1.
    - On the handshake cycle, `nb_valid` is cleared on the next edge. Then go to DONE if i is last, else i++ and go to READ.
  - DONE: `done`=1 for exactly one cycle, `busy`=0 from the next cycle, go to IDLE.
- `du_x1/y1/z1` hold the query registers from CAP_Q+1 through DONE.
- `du_x2/y2/z2` follow `mem_x/y/z` registered at the READ→EVAL edge, so they are stable through EVAL and EMIT.
- Timing (start accepted at edge k):
  - `done` is high in cycle k+3+2N when no neighbours are found (N = num_points).
  - Each neighbour adds 1 cycle plus the `nb_ready` stall cycles.
- Counters and width rules:
  - `i` is CNT_W wide; it never wraps because termination compares with num_points-1.
  - num_points=2^IDX_W scans every address; the last address is 2^IDX_W-1.
  - `neighbor_count` cannot overflow since CNT_W holds 2^IDX_W.
- `query_idx` ≥ `num_points` is legal; the query point is still read from memory.
- `r2`=0: no candidate can be a neighbour, so `neighbor_count`=0.
- Inputs `query_idx`, `num_points` and `r2` may change while busy without effect.

Optional Feature:
- Macro `NSC_SELF_EXCLUDE_EN`.
- Defined: a candidate with i == captured `query_idx` is never emitted or counted, regardless of `du_is_neighbor`. It still consumes its READ/EVAL cycles.
- Undefined: the query point is treated like any candidate, so it is reported as a neighbour whenever r2 > 0.

Test Plan:
1. Reset during EMIT with `nb_valid`=1 → next cycle `nb_valid`=0, `busy`=0, `neighbor_count`=0; no `done` pulse.
2. num_points=4, all points (10,10,10), query_idx=0, r2=1, `nb_ready`=1, feature off → `nb_idx` stream 0,1,2,3; `neighbor_count`=4.
3. Same as scenario 2 with `NSC_SELF_EXCLUDE_EN` → stream 1,2,3; `neighbor_count`=3.
4. num_points=3 with points (0,0,0),(3,4,0),(10,0,0), query_idx=0, r2=26, feature on → only index 1 emitted; `neighbor_count`=1.
5. num_points=0, start at edge k → `done` high in cycle k+3, `neighbor_count`=0, no `nb_valid`.
6. `nb_ready` held low 5 cycles on the first neighbour → `nb_idx` stable and `mem_rd_en`=0 throughout; the scan resumes after the handshake; `start` pulsed while busy is ignored.
